// File: rtl/type_enums.sv
// ----------------------------------------------------------------------------
// type_enums
//   Shared types for the ALU datapath and its requesters.
//   - alu_op_t     : ALU operation encoding (4 bits; codes above ALU_SLTU are
//                    illegal and make the ALU produce a zero result)
//   - FLAG_W       : width of the flag vector {OF,SF,CF,ZF}
//   - FLAG_*       : bit index of each flag inside that vector
//   - alu_req_t    : one request {op, a, b} at the default datapath width
// ----------------------------------------------------------------------------
package type_enums;

    localparam int ALU_OP_W = 4;
    localparam int ALU_W    = 32;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    localparam int FLAG_W  = 4;
    localparam int FLAG_ZF = 0;
    localparam int FLAG_CF = 1;
    localparam int FLAG_SF = 2;
    localparam int FLAG_OF = 3;

    typedef struct packed {
        alu_op_t          op;
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
    } alu_req_t;

endpackage

// File: rtl/alu.sv
// ----------------------------------------------------------------------------
// alu
//   Purely combinational integer ALU.
//   Ports:
//     op        in   alu_op_t   operation select
//     a, b      in   WIDTH      operands
//     out       out  WIDTH      result (no width change)
//     flags_out out  FLAG_W     {OF,SF,CF,ZF}
//   SF and ZF always describe the result. CF and OF are only produced by
//   ADD (carry out / signed overflow) and SUB (borrow / signed overflow) and
//   are zero for every other op. Illegal op codes give result 0.
// ----------------------------------------------------------------------------
module alu
    import type_enums::*;
#(
    parameter int WIDTH = 32
) (
    input  alu_op_t           op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic [WIDTH-1:0]  out,
    output logic [FLAG_W-1:0] flags_out
);

    localparam int SH_W = $clog2(WIDTH);
    localparam int MSB  = WIDTH - 1;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [SH_W-1:0]  shamt;
    logic             of;
    logic             cf;

    // The extra top bit of each extended operation is the carry (ADD) or
    // the borrow (SUB), so CF for SUB means "a < b unsigned".
    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};
    assign shamt    = b[SH_W-1:0];

    // NOTE: every signal written in a combinational block gets a default
    // first, so no path through the case can leave it unassigned (no latch).
    always_comb begin
        out = '0;
        of  = 1'b0;
        cf  = 1'b0;
        case (op)
            ALU_ADD: begin
                out = sum_ext[WIDTH-1:0];
                cf  = sum_ext[WIDTH];
                of  = (a[MSB] == b[MSB]) && (out[MSB] != a[MSB]);
            end
            ALU_SUB: begin
                out = diff_ext[WIDTH-1:0];
                cf  = diff_ext[WIDTH];
                of  = (a[MSB] != b[MSB]) && (out[MSB] != a[MSB]);
            end
            ALU_AND:  out = a & b;
            ALU_OR:   out = a | b;
            ALU_XOR:  out = a ^ b;
            ALU_SLL:  out = a << shamt;
            ALU_SRL:  out = a >> shamt;
            ALU_SRA:  out = $signed(a) >>> shamt;
            ALU_SLT:  out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: out = {{(WIDTH-1){1'b0}}, (a < b)};
            default:  out = '0;
        endcase
    end

    always_comb begin
        flags_out          = '0;
        flags_out[FLAG_OF] = of;
        flags_out[FLAG_SF] = out[MSB];
        flags_out[FLAG_CF] = cf;
        flags_out[FLAG_ZF] = (out == '0);
    end

endmodule

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin arbiter.
//   Ports:
//     req      in   N       request vector
//     ptr      in   IDX_W   highest-priority index for this cycle
//     en       in   1       grant allowed this cycle
//     gnt      out  N       one-hot grant (all zero when en=0 or no request)
//     gnt_idx  out  IDX_W   binary index of the granted requester
//   The search visits ptr, ptr+1, ... wrapping modulo N, so it also works
//   for N that is not a power of two.
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic             found;
    logic [IDX_W:0]   slot;
    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        slot    = '0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            // One spare bit holds ptr+k before the modulo-N wrap.
            slot = {1'b0, ptr} + (IDX_W+1)'(k);
            if (slot >= (IDX_W+1)'(N)) begin
                slot = slot - (IDX_W+1)'(N);
            end
            idx = slot[IDX_W-1:0];
            if (en && !found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = idx;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter
//   Shares one ALU between NREQ requesters. A round-robin arbiter grants one
//   request per cycle; the ALU result and flags of the granted request are
//   registered and returned to the winner over a valid/ready handshake.
//   Ports:
//     clk          in   1              rising-edge clock
//     rst          in   1              synchronous, active-high reset
//     req_valid    in   NREQ           requester i presents an operation
//     req_ready    out  NREQ           requester i is accepted this cycle
//     req_op       in   NREQ x op      operation per requester
//     req_a        in   NREQ x WIDTH   operand A per requester
//     req_b        in   NREQ x WIDTH   operand B per requester
//     resp_valid   out  NREQ           response held for requester i
//     resp_ready   in   NREQ           requester i consumes its response
//     resp_result  out  WIDTH          registered ALU result
//     resp_flags   out  FLAG_W         registered flags {OF,SF,CF,ZF}
//     busy         out  1              response register occupied
//   A new request can be accepted in the same cycle the current response
//   drains, giving one operation per cycle with resp_ready held high.
// ----------------------------------------------------------------------------
module alu_arbiter
    import type_enums::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic    [NREQ-1:0]             req_valid,
    output logic    [NREQ-1:0]             req_ready,
    input  alu_op_t [NREQ-1:0]             req_op,
    input  logic    [NREQ-1:0][WIDTH-1:0]  req_a,
    input  logic    [NREQ-1:0][WIDTH-1:0]  req_b,
    output logic    [NREQ-1:0]             resp_valid,
    input  logic    [NREQ-1:0]             resp_ready,
    output logic    [WIDTH-1:0]            resp_result,
    output logic    [FLAG_W-1:0]           resp_flags,
    output logic                           busy
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Response register occupancy.
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]        state_q;
    logic [IDX_W-1:0]  owner_q;
    logic [IDX_W-1:0]  ptr_q;
    logic [WIDTH-1:0]  result_q;
    logic [FLAG_W-1:0] flags_q;

    logic              slot_free;
    logic              drain;
    logic              accept;
    logic [NREQ-1:0]   gnt;
    logic [IDX_W-1:0]  gnt_idx;

    logic [ALU_OP_W-1:0] sel_op_bits;
    alu_op_t             sel_op;
    logic [WIDTH-1:0]    sel_a;
    logic [WIDTH-1:0]    sel_b;
    logic [WIDTH-1:0]    alu_out;
    logic [FLAG_W-1:0]   alu_flags;

    // Only the owner's resp_ready matters; other bits are ignored.
    assign drain     = (state_q == ST_FULL) && resp_ready[owner_q];
    assign slot_free = (state_q == ST_EMPTY) || drain;

    // Gating with rst keeps req_ready low during reset, so no request is
    // consumed in a cycle whose effect the reset would discard.
    rr_arbiter #(
        .N     (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (ptr_q),
        .en      (slot_free && !rst),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign accept    = |gnt;

    // One-hot AND-OR operand mux; gnt has at most one bit set.
    always_comb begin
        sel_op_bits = '0;
        sel_a       = '0;
        sel_b       = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_op_bits = sel_op_bits | ALU_OP_W'(req_op[i]);
                sel_a       = sel_a | req_a[i];
                sel_b       = sel_b | req_b[i];
            end
        end
    end

    // Illegal codes pass straight through; the ALU decides what they yield.
    assign sel_op = alu_op_t'(sel_op_bits);

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op        (sel_op),
        .a         (sel_a),
        .b         (sel_b),
        .out       (alu_out),
        .flags_out (alu_flags)
    );

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            owner_q  <= '0;
            ptr_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else if (accept) begin
            // Covers both a load into an empty slot and drain+load together.
            state_q  <= ST_FULL;
            owner_q  <= gnt_idx;
            result_q <= alu_out;
            flags_q  <= alu_flags;
            if (gnt_idx == IDX_W'(NREQ - 1)) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= gnt_idx + 1'b1;
            end
        end else if (drain) begin
            // Contents are left as they are; only occupancy changes.
            state_q <= ST_EMPTY;
        end
    end

    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            resp_valid[i] = (state_q == ST_FULL) && (owner_q == IDX_W'(i));
        end
    end

    assign resp_result = result_q;
    assign resp_flags  = flags_q;
    assign busy        = (state_q == ST_FULL);

endmodule

// File: tb/tb_alu_arbiter.sv
// ----------------------------------------------------------------------------
// tb_alu_arbiter
//   Directed scenarios followed by randomized traffic, all compared against a
//   behavioural model of the shared-ALU arbiter (slot occupancy, owner,
//   rotating priority and an arithmetic reference ALU).
// ----------------------------------------------------------------------------
module tb_alu_arbiter;
    import type_enums::*;

    localparam int WIDTH = 32;
    localparam int NREQ  = 2;
    localparam longint S_MAX = 64'sh0000_0000_7FFF_FFFF;
    localparam longint S_MIN = -64'sh0000_0000_8000_0000;

    logic                             clk = 1'b0;
    logic                             rst;
    logic    [NREQ-1:0]               req_valid;
    logic    [NREQ-1:0]               req_ready;
    alu_op_t [NREQ-1:0]               req_op;
    logic    [NREQ-1:0][WIDTH-1:0]    req_a;
    logic    [NREQ-1:0][WIDTH-1:0]    req_b;
    logic    [NREQ-1:0]               resp_valid;
    logic    [NREQ-1:0]               resp_ready;
    logic    [WIDTH-1:0]              resp_result;
    logic    [FLAG_W-1:0]             resp_flags;
    logic                             busy;

    alu_arbiter #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_flags  (resp_flags),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_full   = 1'b0;
    int          m_owner  = 0;
    int          m_ptr    = 0;
    logic [31:0] m_result = '0;
    logic [3:0]  m_flags  = '0;
    int          m_wait [NREQ];
    int          exp_gnt  = -1;
    logic [NREQ-1:0] obs_ready;
    alu_req_t    cur_req [NREQ];

    function automatic void model_alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic [3:0] f);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        logic            of = 1'b0;
        logic            cf = 1'b0;
        case (op)
            ALU_ADD: begin
                r  = 32'(ua + ub);
                cf = (ua + ub) > 64'hFFFF_FFFF;
                of = (sa + sb) > S_MAX || (sa + sb) < S_MIN;
            end
            ALU_SUB: begin
                r  = 32'(ua - ub);
                cf = ua < ub;
                of = (sa - sb) > S_MAX || (sa - sb) < S_MIN;
            end
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_SLL:  r = 32'(ua << b[4:0]);
            ALU_SRL:  r = 32'(ua >> b[4:0]);
            ALU_SRA:  r = 32'(sa >>> b[4:0]);
            ALU_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU: r = (ua < ub) ? 32'd1 : 32'd0;
            default:  r = 32'd0;
        endcase
        f = {of, r[31], cf, (r == 32'd0)};
    endfunction

    function automatic int pick_grant();
        if (rst) return -1;
        if (m_full && !resp_ready[m_owner]) return -1;
        for (int k = 0; k < NREQ; k++) begin
            int idx = (m_ptr + k) % NREQ;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_update();
        if (rst) begin
            m_full = 1'b0; m_owner = 0; m_ptr = 0; m_result = '0; m_flags = '0;
            for (int i = 0; i < NREQ; i++) m_wait[i] = 0;
        end else begin
            for (int i = 0; i < NREQ; i++) if (!req_valid[i]) m_wait[i] = 0;
            // Fairness follows the grants the DUT actually gave.
            for (int g = 0; g < NREQ; g++) begin
                if (obs_ready[g]) begin
                    check("fairness_wait", 64'(m_wait[g] <= NREQ - 1), 64'd1);
                    for (int i = 0; i < NREQ; i++) if (i != g && req_valid[i]) m_wait[i]++;
                    m_wait[g] = 0;
                end
            end
            if (exp_gnt >= 0) begin
                model_alu(req_op[exp_gnt], req_a[exp_gnt], req_b[exp_gnt], m_result, m_flags);
                m_full  = 1'b1;
                m_owner = exp_gnt;
                m_ptr   = (exp_gnt + 1) % NREQ;
            end else if (m_full && resp_ready[m_owner]) begin
                m_full = 1'b0;
            end
        end
    endtask

    // Compare at the falling edge, then advance the model at the rising edge.
    task automatic tick();
        @(negedge clk);
        exp_gnt   = pick_grant();
        obs_ready = req_ready;
        check("req_ready",  64'(req_ready),  (exp_gnt < 0) ? 64'd0 : (64'd1 << exp_gnt));
        check("resp_valid", 64'(resp_valid), m_full ? (64'd1 << m_owner) : 64'd0);
        check("busy",       64'(busy),       64'(m_full));
        check("result",     64'(resp_result), 64'(m_result));
        check("flags",      64'(resp_flags),  64'(m_flags));
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input int i);
        req_op[i] = cur_req[i].op;
        req_a[i]  = cur_req[i].a;
        req_b[i]  = cur_req[i].b;
    endtask

    task automatic set_req(input int i, input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        cur_req[i].op = op;
        cur_req[i].a  = a;
        cur_req[i].b  = b;
        drive(i);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'($urandom_range(0, 40));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic rand_req(input int i);
        set_req(i, alu_op_t'(4'($urandom_range(0, 11))), rand_operand(), rand_operand());
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, ALU_ADD, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        model_update();
        tick();
        rst = 1'b0;
        check("reset_resp_valid", 64'(resp_valid), 64'd0);
        check("reset_busy",       64'(busy),       64'd0);
        check("reset_result",     64'(resp_result), 64'd0);
        check("reset_flags",      64'(resp_flags),  64'd0);

        // 1. single request
        resp_ready = '1;
        set_req(0, ALU_ADD, 32'd5, 32'd7);
        req_valid = 2'b01;
        #1 check("t1_req_ready", 64'(req_ready), 64'b01);
        tick();
        req_valid = 2'b00;
        check("t1_resp_valid", 64'(resp_valid), 64'b01);
        check("t1_result",     64'(resp_result), 64'd12);
        check("t1_flags",      64'(resp_flags),  64'b0000);
        tick();
        check("t1_drained",    64'(resp_valid), 64'b00);

        // 2. overflow flags
        set_req(1, ALU_ADD, 32'h7FFF_FFFF, 32'd1);
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        check("t2_resp_valid", 64'(resp_valid), 64'b10);
        check("t2_result",     64'(resp_result), 64'h8000_0000);
        check("t2_flags",      64'(resp_flags),  64'b1100);
        tick();

        // 3. contention: grants alternate starting at requester 0
        set_req(0, ALU_SUB, 32'd3, 32'd3);
        set_req(1, ALU_XOR, 32'hF0, 32'h0F);
        req_valid = 2'b11;
        #1 check("t3_first_grant", 64'(req_ready), 64'b01);
        tick();
        check("t3_result0", 64'(resp_result), 64'd0);
        check("t3_flags0",  64'(resp_flags),  64'b0001);
        #1 check("t3_second_grant", 64'(req_ready), 64'b10);
        tick();
        check("t3_owner1",  64'(resp_valid), 64'b10);
        check("t3_result1", 64'(resp_result), 64'hFF);
        #1 check("t3_third_grant", 64'(req_ready), 64'b01);
        tick();
        req_valid = 2'b00;
        tick();

        // 4. backpressure from requester 0, then drain+accept together
        set_req(0, ALU_ADD, 32'd1, 32'd1);
        req_valid = 2'b01;
        tick();
        set_req(1, ALU_AND, 32'hFF, 32'h0F);
        req_valid  = 2'b10;
        resp_ready = 2'b10;
        for (int c = 0; c < 3; c++) begin
            #1 check("t4_stalled_ready", 64'(req_ready), 64'b00);
            tick();
            check("t4_held_result", 64'(resp_result), 64'd2);
        end
        resp_ready = 2'b11;
        #1 check("t4_release_ready", 64'(req_ready), 64'b10);
        tick();
        req_valid = 2'b00;
        check("t4_new_owner",  64'(resp_valid), 64'b10);
        check("t4_new_result", 64'(resp_result), 64'h0F);
        tick();

        // 5. streaming from requester 1
        req_valid = 2'b10;
        set_req(1, ALU_SLL, 32'd1, 32'd4);
        tick();
        check("t5_sll", 64'(resp_result), 64'd16);
        set_req(1, ALU_SRL, 32'h8000_0000, 32'd31);
        tick();
        check("t5_srl", 64'(resp_result), 64'd1);
        set_req(1, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
        tick();
        check("t5_slt", 64'(resp_result), 64'd1);
        set_req(1, ALU_SLTU, 32'hFFFF_FFFF, 32'd1);
        tick();
        check("t5_sltu", 64'(resp_result), 64'd0);
        check("t5_valid", 64'(resp_valid), 64'b10);
        req_valid = 2'b00;
        tick();

        // illegal op code yields a zero result with ZF
        set_req(0, alu_op_t'(4'd12), 32'd5, 32'd5);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        check("illegal_result", 64'(resp_result), 64'd0);
        check("illegal_flags",  64'(resp_flags),  64'b0001);
        tick();

        // 6. reset while a response is pending
        set_req(1, ALU_ADD, 32'd2, 32'd3);
        req_valid  = 2'b10;
        resp_ready = 2'b00;
        tick();
        check("t6_pending", 64'(resp_valid), 64'b10);
        set_req(0, ALU_OR, 32'h1, 32'h2);
        rst = 1'b1;
        req_valid = 2'b11;
        #1 check("t6_no_grant_in_reset", 64'(req_ready), 64'b00);
        tick();
        rst = 1'b0;
        check("t6_resp_valid", 64'(resp_valid), 64'b00);
        check("t6_busy",       64'(busy),       64'b0);
        check("t6_result",     64'(resp_result), 64'd0);
        #1 check("t6_grant_req0", 64'(req_ready), 64'b01);
        tick();

        // reset with pointer at 1 must return priority to requester 0
        req_valid  = 2'b00;
        resp_ready = 2'b11;
        tick();
        set_req(0, ALU_ADD, 32'd1, 32'd2);
        req_valid  = 2'b01;
        resp_ready = 2'b00;
        tick();
        rst       = 1'b1;
        req_valid = 2'b11;
        tick();
        rst = 1'b0;
        #1 check("ptr_reset_grant", 64'(req_ready), 64'b01);
        tick();

        // randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && obs_ready[i]) begin
                    if ($urandom_range(0, 3) != 0) rand_req(i);
                    else req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
                    rand_req(i);
                    req_valid[i] = 1'b1;
                end
            end
            resp_ready = NREQ'($urandom);
            rst        = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
